// File: rtl/inst_queue_pkg.sv
// Shared types and constants for the dual-issue instruction queue.
package inst_queue_pkg;

    localparam int unsigned IQ_DEPTH = 16;
    localparam int unsigned POP_MAX  = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        branch;
    } iq_entry_t;

endpackage

// File: rtl/inst_queue_ram.sv
// Entry storage: two writes at consecutive addresses, two combinational
// reads at consecutive addresses. Contents are not reset.
module inst_queue_ram
    import inst_queue_pkg::*;
#(
    parameter int unsigned DEPTH  = IQ_DEPTH,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              wr0_en,
    input  logic              wr1_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  iq_entry_t         wr0_data,
    input  iq_entry_t         wr1_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output iq_entry_t         rd0_data,
    output iq_entry_t         rd1_data
);

    iq_entry_t         mem [DEPTH];
    logic [ADDR_W-1:0] wr_addr_nxt;
    logic [ADDR_W-1:0] rd_addr_nxt;

    // Second port addresses are the first plus one, wrapping naturally.
    always_comb begin
        wr_addr_nxt = wr_addr + ADDR_W'(1);
        rd_addr_nxt = rd_addr + ADDR_W'(1);
    end

    // Registered writes, older slot at wr_addr.
    always_ff @(posedge clk) begin
        if (wr0_en)
            mem[wr_addr] <= wr0_data;
        if (wr1_en)
            mem[wr_addr_nxt] <= wr1_data;
    end

    // Combinational reads of the two oldest locations.
    always_comb begin
        rd0_data = mem[rd_addr];
        rd1_data = mem[rd_addr_nxt];
    end

endmodule

// File: rtl/inst_queue.sv
// Dual-issue instruction queue between fetch and decode with
// branch-delay-slot tracking and synchronous flush.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int unsigned DEPTH  = IQ_DEPTH,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push_first_valid,
    input  logic [31:0]       push_first_pc,
    input  logic [31:0]       push_first_instr,
    input  logic              push_first_branch,
    input  logic              push_second_valid,
    input  logic [31:0]       push_second_pc,
    input  logic [31:0]       push_second_instr,
    input  logic              push_second_branch,
    input  logic [1:0]        pop_count,
    output logic              full,
    output logic              head_first_valid,
    output logic [31:0]       head_first_pc,
    output logic [31:0]       head_first_instr,
    output logic              head_first_branch,
    output logic              head_first_in_delayslot,
    output logic              head_second_valid,
    output logic [31:0]       head_second_pc,
    output logic [31:0]       head_second_instr,
    output logic              head_second_branch,
    output logic              head_second_in_delayslot,
    output logic [ADDR_W:0]   count
);

    localparam int unsigned CW = ADDR_W + 1;

    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_ptr;
    logic [CW-1:0]     count_q;
    logic              last_pop_branch;

    iq_entry_t         wr0_data;
    iq_entry_t         wr1_data;
    iq_entry_t         rd0_data;
    iq_entry_t         rd1_data;
    logic              wr0_en;
    logic              wr1_en;
    logic [1:0]        push_num;
    logic [1:0]        pop_req;
    logic [1:0]        pop_num;
    logic              push_ok;
    logic              head0_v;
    logic              head1_v;

    inst_queue_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk      (clk),
        .wr0_en   (wr0_en),
        .wr1_en   (wr1_en),
        .wr_addr  (wr_ptr),
        .wr0_data (wr0_data),
        .wr1_data (wr1_data),
        .rd_addr  (rd_ptr),
        .rd0_data (rd0_data),
        .rd1_data (rd1_data)
    );

    // Occupancy flags from the registered count.
    always_comb begin
        head0_v = (count_q != '0);
        head1_v = (count_q > CW'(1));
        full    = (count_q > CW'(DEPTH - 2));
        count   = count_q;
    end

    // Compact valid push slots in age order so a lone second slot lands at wr_ptr.
    always_comb begin
        wr0_data = '{pc: push_first_pc,  instr: push_first_instr,  branch: push_first_branch};
        wr1_data = '{pc: push_second_pc, instr: push_second_instr, branch: push_second_branch};
        if (!push_first_valid)
            wr0_data = wr1_data;
        push_num = 2'(push_first_valid) + 2'(push_second_valid);
        push_ok  = (push_num != 2'd0) && !full && !flush;
        wr0_en   = push_ok;
        wr1_en   = push_ok && (push_num == 2'd2);
    end

    // Clamp the requested pop to POP_MAX and to what is actually present.
    always_comb begin
        pop_req = (pop_count > 2'(POP_MAX)) ? 2'(POP_MAX) : pop_count;
        pop_num = (CW'(pop_req) > count_q) ? count_q[1:0] : pop_req;
    end

    // Pointer, count and delay-slot state; flush outranks push and pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            count_q         <= '0;
            last_pop_branch <= 1'b0;
        end else if (flush) begin
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            count_q         <= '0;
            last_pop_branch <= 1'b0;
        end else begin
            rd_ptr  <= rd_ptr + ADDR_W'(pop_num);
            if (push_ok)
                wr_ptr <= wr_ptr + ADDR_W'(push_num);
            count_q <= count_q + CW'(push_ok ? push_num : 2'd0) - CW'(pop_num);
            if (pop_num == 2'd1)
                last_pop_branch <= rd0_data.branch;
            else if (pop_num == 2'd2)
                last_pop_branch <= rd1_data.branch;
        end
    end

    // Head outputs, zeroed when the slot is empty.
    always_comb begin
        head_first_valid         = head0_v;
        head_first_pc            = head0_v ? rd0_data.pc    : '0;
        head_first_instr         = head0_v ? rd0_data.instr : '0;
        head_first_branch        = head0_v & rd0_data.branch;
        head_first_in_delayslot  = head0_v & last_pop_branch;
        head_second_valid        = head1_v;
        head_second_pc           = head1_v ? rd1_data.pc    : '0;
        head_second_instr        = head1_v ? rd1_data.instr : '0;
        head_second_branch       = head1_v & rd1_data.branch;
        head_second_in_delayslot = head1_v & head_first_branch;
    end

    // Fetch must respect full; such a push is dropped.
    always_ff @(posedge clk) begin
        if (!rst && !flush)
            assert (!(full && (push_first_valid || push_second_valid)))
            else $warning("inst_queue: push while full dropped");
    end

endmodule

// File: tb/tb_inst_queue.sv
module tb_inst_queue;
    import inst_queue_pkg::*;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        pfv, pfb, psv, psb;
    logic [31:0] pfpc, pfin, pspc, psin;
    logic [1:0]  pop_count;
    logic        full;
    logic        hfv, hfb, hfds, hsv, hsb, hsds;
    logic [31:0] hfpc, hfin, hspc, hsin;
    logic [ADDR_W:0] count;

    int checks   = 0;
    int failures = 0;

    iq_entry_t sb[$];
    logic      m_lpb;

    always #5 clk = ~clk;

    inst_queue #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .flush                    (flush),
        .push_first_valid         (pfv),
        .push_first_pc            (pfpc),
        .push_first_instr         (pfin),
        .push_first_branch        (pfb),
        .push_second_valid        (psv),
        .push_second_pc           (pspc),
        .push_second_instr        (psin),
        .push_second_branch       (psb),
        .pop_count                (pop_count),
        .full                     (full),
        .head_first_valid         (hfv),
        .head_first_pc            (hfpc),
        .head_first_instr         (hfin),
        .head_first_branch        (hfb),
        .head_first_in_delayslot  (hfds),
        .head_second_valid        (hsv),
        .head_second_pc           (hspc),
        .head_second_instr        (hsin),
        .head_second_branch       (hsb),
        .head_second_in_delayslot (hsds),
        .count                    (count)
    );

    typedef struct {
        logic        fv;
        logic [31:0] pc1;
        logic        br1;
        logic        sv;
        logic [31:0] pc2;
        logic        br2;
        logic [1:0]  pop;
        int unsigned exp_count;
        logic        exp_full;
        logic [31:0] exp_hf_pc;
        logic [31:0] exp_hs_pc;
        logic        exp_hf_ds;
        logic        exp_hs_ds;
    } vec_t;

    vec_t vecs[15];

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'hDEAD_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT head/count against the scoreboard front.
    task automatic check_state();
        int n;
        n = sb.size();
        chk("sb_count", 32'(count), 32'(n));
        chk("sb_full", 32'(full), 32'(n > int'(DEPTH) - 2));
        chk("sb_hf_valid", 32'(hfv), 32'(n >= 1));
        chk("sb_hs_valid", 32'(hsv), 32'(n >= 2));
        if (n >= 1) begin
            chk("sb_hf_pc", hfpc, sb[0].pc);
            chk("sb_hf_instr", hfin, sb[0].instr);
            chk("sb_hf_branch", 32'(hfb), 32'(sb[0].branch));
            chk("sb_hf_ds", 32'(hfds), 32'(m_lpb));
        end else begin
            chk("sb_hf_zero", {hfpc[31:1], hfpc[0] | hfb | hfds}, 32'h0);
            chk("sb_hf_instr_zero", hfin, 32'h0);
        end
        if (n >= 2) begin
            chk("sb_hs_pc", hspc, sb[1].pc);
            chk("sb_hs_instr", hsin, sb[1].instr);
            chk("sb_hs_branch", 32'(hsb), 32'(sb[1].branch));
            chk("sb_hs_ds", 32'(hsds), 32'(sb[0].branch));
        end else begin
            chk("sb_hs_zero", {hspc[31:1], hspc[0] | hsb | hsds}, 32'h0);
            chk("sb_hs_instr_zero", hsin, 32'h0);
        end
    endtask

    // One clock: drive, check pre-edge state, update the scoreboard, step.
    task automatic do_cycle(input logic fv, input logic [31:0] pc1, input logic br1,
                            input logic sv, input logic [31:0] pc2, input logic br2,
                            input logic [1:0] pop, input logic fl);
        int n;
        int p;
        bit was_full;
        iq_entry_t e;
        pfv = fv; pfpc = pc1; pfin = instr_of(pc1); pfb = br1;
        psv = sv; pspc = pc2; psin = instr_of(pc2); psb = br2;
        pop_count = pop; flush = fl;
        #1;
        check_state();
        n = sb.size();
        was_full = (n > int'(DEPTH) - 2);
        if (fl) begin
            sb.delete();
            m_lpb = 1'b0;
        end else begin
            p = (pop == 2'd3) ? 2 : int'(pop);
            if (p > n) p = n;
            for (int i = 0; i < p; i++) begin
                m_lpb = sb[0].branch;
                void'(sb.pop_front());
            end
            if (!was_full) begin
                if (fv) begin
                    e.pc = pc1; e.instr = instr_of(pc1); e.branch = br1;
                    sb.push_back(e);
                end
                if (sv) begin
                    e.pc = pc2; e.instr = instr_of(pc2); e.branch = br2;
                    sb.push_back(e);
                end
            end
        end
        @(posedge clk);
        #1;
        pfv = 1'b0; psv = 1'b0; pop_count = 2'd0; flush = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; pop_count = 2'd0;
        pfv = 1'b0; pfpc = '0; pfin = '0; pfb = 1'b0;
        psv = 1'b0; pspc = '0; psin = '0; psb = 1'b0;
        m_lpb = 1'b0;

        //            fv  pc1           br  sv  pc2           br  pop  cnt full hf_pc         hs_pc         fds sds
        vecs[0]  = '{1'b1, 32'h1000, 1'b0, 1'b1, 32'h1004, 1'b0, 2'd0, 2, 1'b0, 32'h1000, 32'h1004, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 32'h0,    1'b0, 1'b0, 32'h0,    1'b0, 2'd2, 0, 1'b0, 32'h0,    32'h0,    1'b0, 1'b0};
        vecs[2]  = '{1'b1, 32'h2000, 1'b1, 1'b1, 32'h2004, 1'b0, 2'd0, 2, 1'b0, 32'h2000, 32'h2004, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 32'h0,    1'b0, 1'b0, 32'h0,    1'b0, 2'd1, 1, 1'b0, 32'h2004, 32'h0,    1'b1, 1'b0};
        vecs[4]  = '{1'b0, 32'h0,    1'b0, 1'b0, 32'h0,    1'b0, 2'd1, 0, 1'b0, 32'h0,    32'h0,    1'b0, 1'b0};
        vecs[5]  = '{1'b0, 32'h0,    1'b0, 1'b1, 32'h3000, 1'b0, 2'd0, 1, 1'b0, 32'h3000, 32'h0,    1'b0, 1'b0};
        vecs[6]  = '{1'b1, 32'h3004, 1'b0, 1'b1, 32'h3008, 1'b0, 2'd2, 2, 1'b0, 32'h3004, 32'h3008, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 32'h300C, 1'b0, 1'b0, 32'h0,    1'b0, 2'd0, 3, 1'b0, 32'h3004, 32'h3008, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 32'h3010, 1'b0, 1'b1, 32'h3014, 1'b0, 2'd2, 3, 1'b0, 32'h300C, 32'h3010, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 32'h0,    1'b0, 1'b0, 32'h0,    1'b0, 2'd2, 1, 1'b0, 32'h3014, 32'h0,    1'b0, 1'b0};
        vecs[10] = '{1'b0, 32'h0,    1'b0, 1'b0, 32'h0,    1'b0, 2'd3, 0, 1'b0, 32'h0,    32'h0,    1'b0, 1'b0};
        vecs[11] = '{1'b0, 32'h0,    1'b0, 1'b0, 32'h0,    1'b0, 2'd3, 0, 1'b0, 32'h0,    32'h0,    1'b0, 1'b0};
        vecs[12] = '{1'b1, 32'h4000, 1'b0, 1'b1, 32'h4004, 1'b1, 2'd0, 2, 1'b0, 32'h4000, 32'h4004, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 32'h4008, 1'b0, 1'b0, 32'h0,    1'b0, 2'd2, 1, 1'b0, 32'h4008, 32'h0,    1'b1, 1'b0};
        vecs[14] = '{1'b0, 32'h0,    1'b0, 1'b0, 32'h0,    1'b0, 2'd1, 0, 1'b0, 32'h0,    32'h0,    1'b0, 1'b0};

        // Reset state, observed while rst is held.
        #3;
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_valids", {30'h0, hfv, hsv}, 32'h0);
        chk("rst_hf_pc", hfpc, 32'h0);
        chk("rst_hf_instr", hfin, 32'h0);
        chk("rst_hs_pc", hspc, 32'h0);
        chk("rst_hs_instr", hsin, 32'h0);
        chk("rst_flags", {28'h0, hfb, hfds, hsb, hsds}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Table-driven vectors with hand-derived post-edge expectations.
        for (int i = 0; i < 15; i++) begin
            do_cycle(vecs[i].fv, vecs[i].pc1, vecs[i].br1, vecs[i].sv, vecs[i].pc2,
                     vecs[i].br2, vecs[i].pop, 1'b0);
            chk($sformatf("v%0d_count", i), 32'(count), vecs[i].exp_count);
            chk($sformatf("v%0d_full", i), 32'(full), 32'(vecs[i].exp_full));
            chk($sformatf("v%0d_hf_pc", i), hfpc, vecs[i].exp_hf_pc);
            chk($sformatf("v%0d_hs_pc", i), hspc, vecs[i].exp_hs_pc);
            chk($sformatf("v%0d_hf_ds", i), 32'(hfds), 32'(vecs[i].exp_hf_ds));
            chk($sformatf("v%0d_hs_ds", i), 32'(hsds), 32'(vecs[i].exp_hs_ds));
        end

        // Fill to 14, then one more to 15 -> full.
        for (int i = 0; i < 7; i++)
            do_cycle(1'b1, 32'h5000 + 32'(8 * i), 1'b0, 1'b1, 32'h5004 + 32'(8 * i), 1'b0, 2'd0, 1'b0);
        chk("fill14_count", 32'(count), 32'd14);
        chk("fill14_full", 32'(full), 32'h0);
        do_cycle(1'b1, 32'h5038, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 1'b0);
        chk("fill15_count", 32'(count), 32'd15);
        chk("fill15_full", 32'(full), 32'h1);
        // Push while full is dropped.
        do_cycle(1'b1, 32'hBAD0, 1'b0, 1'b1, 32'hBAD4, 1'b0, 2'd0, 1'b0);
        chk("drop_count", 32'(count), 32'd15);
        chk("drop_hf_pc", hfpc, 32'h5000);
        do_cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 2'd2, 1'b0);
        chk("pop_unfull_count", 32'(count), 32'd13);
        chk("pop_unfull_full", 32'(full), 32'h0);
        // Steady push-2/pop-2 across pointer wrap.
        for (int i = 0; i < 40; i++)
            do_cycle(1'b1, 32'h8000 + 32'(8 * i), 1'(i % 3 == 0), 1'b1, 32'h8004 + 32'(8 * i),
                     1'(i % 5 == 0), 2'd2, 1'b0);
        chk("wrap_count", 32'(count), 32'd13);
        for (int i = 0; i < 7; i++)
            do_cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 2'd3, 1'b0);
        chk("drain_count", 32'(count), 32'h0);

        // Flush with count=6, delay-slot set, and a same-cycle push and pop.
        do_cycle(1'b1, 32'h6000, 1'b1, 1'b1, 32'h6004, 1'b0, 2'd0, 1'b0);
        do_cycle(1'b1, 32'h6008, 1'b0, 1'b1, 32'h600C, 1'b0, 2'd1, 1'b0);
        do_cycle(1'b1, 32'h6010, 1'b0, 1'b1, 32'h6014, 1'b0, 2'd0, 1'b0);
        do_cycle(1'b1, 32'h6018, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 1'b0);
        chk("preflush_count", 32'(count), 32'd6);
        chk("preflush_hf_ds", 32'(hfds), 32'h1);
        do_cycle(1'b1, 32'h6100, 1'b0, 1'b1, 32'h6104, 1'b0, 2'd2, 1'b1);
        chk("flush_count", 32'(count), 32'h0);
        chk("flush_valids", {30'h0, hfv, hsv}, 32'h0);
        do_cycle(1'b1, 32'h7000, 1'b0, 1'b1, 32'h7004, 1'b0, 2'd0, 1'b0);
        chk("postflush_hf_pc", hfpc, 32'h7000);
        chk("postflush_hf_ds", 32'(hfds), 32'h0);
        do_cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 2'd2, 1'b0);

        // Asynchronous reset mid-operation with the queue half full.
        for (int i = 0; i < 4; i++)
            do_cycle(1'b1, 32'h9000 + 32'(8 * i), 1'b1, 1'b1, 32'h9004 + 32'(8 * i), 1'b0, 2'd0, 1'b0);
        chk("prerst_count", 32'(count), 32'd8);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count", 32'(count), 32'h0);
        chk("arst_valids", {30'h0, hfv, hsv}, 32'h0);
        chk("arst_hf_pc", hfpc, 32'h0);
        chk("arst_hs_pc", hspc, 32'h0);
        chk("arst_flags", {27'h0, full, hfb, hfds, hsb, hsds}, 32'h0);
        sb.delete();
        m_lpb = 1'b0;
        #1;
        rst = 1'b0;
        do_cycle(1'b1, 32'hA000, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 1'b0);
        do_cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
